// File: rtl/control_fsm.sv
// Multicycle RISC-V main controller: Moore state register plus combinational output/next-state decode.
// Define JALR_SUPPORT_EN to add the two-step jalr sequence (JALR -> JALRLINK); otherwise jalr decodes as illegal.
module control_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] Op,
  input  logic [2:0] Funct3,
  input  logic       Funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic       Illegal,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [2:0] ALUControl,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    JALR     = 4'd11,
    JALRLINK = 4'd12
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t state_reg, state_next;

  logic mem_read, mem_write, ir_write, pc_write, reg_write, illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= FETCH;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    AdrSrc     = 1'b0;
    ImmSrc     = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = ALU_ADD;

    case (state_reg)
      FETCH: begin
        mem_read  = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_write  = MemReady;
        pc_write  = MemReady;
        if (MemReady) state_next = DECODE;
      end
      // Precompute the branch target into ALUOut while the opcode is decoded.
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 2'b10;
        case (Op)
          OP_LOAD, OP_STORE: state_next = MEMADR;
          OP_RTYPE:          state_next = EXECR;
          OP_ITYPE:          state_next = EXECI;
          OP_BRANCH:         state_next = BRANCH;
          OP_JAL:            state_next = JAL;
`ifdef JALR_SUPPORT_EN
          OP_JALR:           state_next = JALR;
`endif
          default: begin
            illegal    = 1'b1;
            state_next = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ImmSrc     = Op[5] ? 2'b01 : 2'b00;
        state_next = Op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_read = 1'b1;
        AdrSrc   = 1'b1;
        if (MemReady) state_next = MEMWB;
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      MEMWRITE: begin
        mem_write = 1'b1;
        AdrSrc    = 1'b1;
        if (MemReady) state_next = FETCH;
      end
      EXECR, EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = (state_reg == EXECI) ? 2'b01 : 2'b00;
        state_next = ALUWB;
        case (Funct3)
          3'b000:  ALUControl = (state_reg == EXECR && Funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  ALUControl = ALU_SLT;
          3'b110:  ALUControl = ALU_OR;
          3'b111:  ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
      ALUWB: begin
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        state_next = FETCH;
        case (Funct3)
          3'b000:  pc_write = Zero;
          3'b001:  pc_write = ~Zero;
          default: pc_write = 1'b0;
        endcase
      end
      // PC jumps to the target now; ALUWB later writes OldPC+4 to rd.
      JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        ImmSrc     = 2'b11;
        pc_write   = 1'b1;
        state_next = ALUWB;
      end
`ifdef JALR_SUPPORT_EN
      JALR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        pc_write   = 1'b1;
        state_next = JALRLINK;
      end
      JALRLINK: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        state_next = ALUWB;
      end
`endif
      default: state_next = FETCH;
    endcase
  end

  // Strobes are masked during reset so FETCH's read/load enables stay quiet.
  assign MemRead  = rst_n & mem_read;
  assign MemWrite = rst_n & mem_write;
  assign IRWrite  = rst_n & ir_write;
  assign PCWrite  = rst_n & pc_write;
  assign RegWrite = rst_n & reg_write;
  assign Illegal  = rst_n & illegal;
  assign State    = state_reg;

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have port clk  input  1  sole clock, rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port Op  input  7  instruction bits [6:0].
REQ-004 SHALL have port Funct3  input  3  instruction bits [14:12].
REQ-005 SHALL have port Funct7b5  input  1  instruction bit 30.
REQ-006 SHALL have port Zero  input  1  ALU zero flag.
REQ-007 SHALL have port MemReady  input  1  memory access completes this cycle.
REQ-008 SHALL have ports MemRead, MemWrite, IRWrite, PCWrite, RegWrite, AdrSrc, Illegal  output  1 each  memory read strobe, memory write strobe, instruction-register load, PC load, register-file write, address select (0=PC, 1=ALUOut), one-cycle undefined-opcode pulse.
REQ-009 SHALL have ports ImmSrc, ALUSrcA, ALUSrcB, ResultSrc  output  2 each  immediate format (00 I, 01 S, 10 B, 11 J); A source (00 PC, 01 OldPC, 10 rs1); B source (00 rs2, 01 Imm, 10 const 4); result (00 ALUOut, 01 ReadData, 10 ALUResult).
REQ-010 SHALL have port ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-011 SHALL have port State  output  4  current state code, debug.

Function
REQ-012 SHALL be a Moore FSM with codes FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11, JALRLINK 12; the state register SHALL be the only storage.
REQ-013 Unlisted outputs SHALL be 0 in every state; ALUControl SHALL default to add.
REQ-014 FETCH: MemRead=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10; IRWrite=PCWrite=MemReady; hold until MemReady=1, then DECODE.
REQ-015 DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=10 (branch target into ALUOut); next by Op: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BRANCH, 1101111->JAL, 1100111->JALR; any other Op -> FETCH with Illegal=1 that cycle.
REQ-016 MEMADR: ALUSrcA=10, ALUSrcB=01, ImmSrc=00 if Op[5]=0 else 01; next MEMREAD if Op[5]=0 else MEMWRITE.
REQ-017 MEMREAD: MemRead=1, AdrSrc=1; hold until MemReady, then MEMWB.
REQ-018 MEMWB: ResultSrc=01, RegWrite=1; next FETCH.
REQ-019 MEMWRITE: MemWrite=1, AdrSrc=1; hold until MemReady, then FETCH.
REQ-020 EXECR: ALUSrcA=10, ALUSrcB=00; EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=00; both next ALUWB.
REQ-021 ALU decode in EXECR/EXECI by Funct3: 000 -> sub only when EXECR and Funct7b5=1, else add; 010 slt; 110 or; 111 and; all others add.
REQ-022 ALUWB: ResultSrc=00, RegWrite=1; next FETCH.
REQ-023 BRANCH: ALUSrcA=10, ALUSrcB=00, ALUControl=sub, ResultSrc=00; PCWrite=Zero when Funct3=000, ~Zero when Funct3=001, else 0; next FETCH.
REQ-024 JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1; ImmSrc=11; next ALUWB (writes OldPC+4).
REQ-025 Each instruction SHALL take exactly: lw 5, sw 4, R/I-type 4, branch 3, jal 4, jalr 5 cycles, plus one per extra cycle MemReady is low in FETCH/MEMREAD/MEMWRITE.
REQ-026 Illegal SHALL never be high outside DECODE.

Reset
REQ-027 rst_n low SHALL immediately force state to FETCH, independent of clk.
REQ-028 While rst_n is low, MemRead, MemWrite, IRWrite, PCWrite, RegWrite and Illegal SHALL be 0; all other outputs SHALL show FETCH values; State SHALL read 0.
REQ-029 Reset asserted mid-instruction SHALL abandon it; first rising edge after release SHALL evaluate FETCH.

Configuration
REQ-030 Macro JALR_SUPPORT_EN defined: Op 1100111 -> JALR (ALUSrcA=10, ALUSrcB=01, ImmSrc=00, ResultSrc=10, PCWrite=1) -> JALRLINK (ALUSrcA=01, ALUSrcB=10, add) -> ALUWB.
REQ-031 Macro undefined: Op 1100111 SHALL be illegal (REQ-015); codes 11 and 12 SHALL be unreachable.

Verification
REQ-032 rst_n low mid-MEMREAD -> State=0 and all strobes 0 without clock edge; release -> FETCH MemRead=1.
REQ-033 lw (Op 0000011), MemReady held 0 for 2 FETCH cycles then 1 -> States 0,0,0,1,2,3,4,0; IRWrite/PCWrite high only third cycle; RegWrite high in MEMWB.
REQ-034 R-type Funct3=000 Funct7b5=1 -> ALUControl=001 in EXECR; same with Op 0010011 -> 000.
REQ-035 beq Funct3=000 with Zero=1 -> PCWrite=1 in BRANCH; Zero=0 -> 0; bne inverts.
REQ-036 Op 1111111 -> Illegal=1 for exactly the DECODE cycle, next State=0.
REQ-037 Op 1100111 with JALR_SUPPORT_EN -> States 1,11,12,8,0; without macro -> Illegal=1, State 0.
